// File: rtl/io_bus_pkg.sv
// Shared types and constants for the CPU-side IO bus controller.
// The highest device index is never decoded; it doubles as the parked "no select" value.
package io_bus_pkg;
  localparam int          NUM_DEV      = 8;
  localparam int          DEV_W        = 3;
  localparam int          WS_W         = 4;
  localparam logic [2:0]  UNMAPPED_DEV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } bus_state_t;
endpackage

// File: rtl/io_ws_table.sv
// Per-device wait-state register file: one write port, one combinational read port.
module io_ws_table
  import io_bus_pkg::*;
#(
  parameter logic [WS_W-1:0] DEFAULT_WS = 4'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DEV_W-1:0] wr_dev,
  input  logic [WS_W-1:0]  wr_ws,
  input  logic [DEV_W-1:0] rd_dev,
  output logic [WS_W-1:0]  rd_ws
);
  logic [WS_W-1:0] ws_reg [NUM_DEV];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset)
          ws_reg[gi] <= DEFAULT_WS;
        else if (wr_en && (wr_dev == DEV_W'(gi)))
          ws_reg[gi] <= wr_ws;
      end
    end
  endgenerate

  assign rd_ws = ws_reg[rd_dev];
endmodule

// File: rtl/io_bus_ctrl.sv
// CPU to IO-decode bus sequencer: IDLE -> SETUP -> ACCESS (ws+1 cycles) -> DONE,
// with a short-circuit error response for the unmapped device.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter logic [WS_W-1:0] DEFAULT_WS = 4'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DEV_W-1:0] cpu_dev,
  input  logic [1:0]       cpu_reg,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic             cpu_busy,
  output logic [DEV_W-1:0] dev_sel,
  output logic [1:0]       reg_sel,
  output logic             we,
  output logic [15:0]      data_out,
  input  logic [15:0]      data_in,
  input  logic             cfg_we,
  input  logic [DEV_W-1:0] cfg_dev,
  input  logic [WS_W-1:0]  cfg_ws
);
  bus_state_t       state_reg, state_next;
  logic             we_reg;
  logic [DEV_W-1:0] dev_reg;
  logic [1:0]       reg_reg;
  logic [15:0]      wdata_reg;
  logic             err_reg;
  logic [WS_W-1:0]  count_reg;
  logic [15:0]      rdata_reg;
  logic [WS_W-1:0]  tbl_ws;

  io_ws_table #(.DEFAULT_WS(DEFAULT_WS)) u_ws_table (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (cfg_we),
    .wr_dev (cfg_dev),
    .wr_ws  (cfg_ws),
    .rd_dev (dev_reg),
    .rd_ws  (tbl_ws)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      dev_reg   <= UNMAPPED_DEV;
      reg_reg   <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      count_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && cpu_req) begin
        err_reg <= (cpu_dev == UNMAPPED_DEV);
        if (cpu_dev != UNMAPPED_DEV) begin
          we_reg    <= cpu_we;
          dev_reg   <= cpu_dev;
          reg_reg   <= cpu_reg;
          wdata_reg <= cpu_wdata;
        end
      end
      // Table is read in SETUP, so a cfg write landing on the acceptance edge is honoured.
      if (state_reg == ST_SETUP)
        count_reg <= tbl_ws;
      if (state_reg == ST_ACCESS) begin
        if (count_reg != '0)
          count_reg <= count_reg - 1'b1;
        else if (!we_reg)
          rdata_reg <= data_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    dev_sel    = UNMAPPED_DEV;
    reg_sel    = '0;
    we         = 1'b0;
    data_out   = '0;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    cpu_busy   = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (cpu_req)
          state_next = (cpu_dev == UNMAPPED_DEV) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: begin
        dev_sel    = dev_reg;
        reg_sel    = reg_reg;
        data_out   = wdata_reg;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        dev_sel  = dev_reg;
        reg_sel  = reg_reg;
        data_out = wdata_reg;
        we       = we_reg;
        if (count_reg == '0)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack    = 1'b1;
        cpu_err    = err_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cpu_rdata = rdata_reg;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed plus randomized bench for io_bus_ctrl; expected behaviour comes from a
// latency/table model (ack at T+3+ws, T+1 for the unmapped device).
module tb_io_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_dev;
  logic [1:0]  cpu_reg;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic [2:0]  dev_sel;
  logic [1:0]  reg_sel;
  logic        we;
  logic [15:0] data_out, data_in;
  logic        cfg_we;
  logic [2:0]  cfg_dev;
  logic [3:0]  cfg_ws;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          model_ws [8];
  logic [15:0] model_rdata;

  io_bus_ctrl #(.DEFAULT_WS(4'd1)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_dev(cpu_dev), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .dev_sel(dev_sel), .reg_sel(reg_sel), .we(we),
    .data_out(data_out), .data_in(data_in), .cfg_we(cfg_we),
    .cfg_dev(cfg_dev), .cfg_ws(cfg_ws)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, cpu_busy, 0);
    check({tag, "_ack"}, cpu_ack, 0);
    check({tag, "_err"}, cpu_err, 0);
    check({tag, "_dev_sel"}, dev_sel, 7);
    check({tag, "_reg_sel"}, reg_sel, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_rdata"}, cpu_rdata, model_rdata);
  endtask

  task automatic scramble();
    cpu_we    = 1'($urandom);
    cpu_dev   = 3'($urandom);
    cpu_reg   = 2'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  // Called just after a negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input string tag, input logic t_we, input logic [2:0] t_dev,
                        input logic [1:0] t_reg, input logic [15:0] t_wdata,
                        input logic [15:0] t_din, input bit keep_req, input bit cfg_now,
                        input bit cfg_mid, input logic [3:0] cfg_val, output int ack_cyc);
    int ws, last, acc;
    bit unmapped;
    check_idle({tag, "_idle"});
    cpu_req = 1'b1; cpu_we = t_we; cpu_dev = t_dev; cpu_reg = t_reg; cpu_wdata = t_wdata;
    if (cfg_now) begin
      cfg_we = 1'b1; cfg_dev = t_dev; cfg_ws = cfg_val;
      model_ws[t_dev] = int'(cfg_val);
    end
    unmapped = (t_dev == 3'd7);
    ws   = model_ws[t_dev];
    last = unmapped ? 1 : ws + 3;
    acc  = cyc;
    ack_cyc = -1;
    data_in = 16'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      check({tag, "_busy"}, cpu_busy, 1);
      if (k == last) begin
        check({tag, "_ack"}, cpu_ack, 1);
        check({tag, "_err"}, cpu_err, unmapped);
        check({tag, "_we_done"}, we, 0);
        check({tag, "_latency"}, 16'(cyc - acc), 16'(last));
        if (!unmapped && !t_we) model_rdata = t_din;
        check({tag, "_rdata_done"}, cpu_rdata, model_rdata);
        if (unmapped) check({tag, "_dev_sel_err"}, dev_sel, 7);
        ack_cyc = cyc;
      end else begin
        check({tag, "_ack_early"}, cpu_ack, 0);
        check({tag, "_dev_sel"}, dev_sel, t_dev);
        check({tag, "_reg_sel"}, reg_sel, t_reg);
        check({tag, "_data_out"}, data_out, t_wdata);
        check({tag, "_we"}, we, (k == 1) ? 1'b0 : t_we);
        check({tag, "_rdata_hold"}, cpu_rdata, model_rdata);
      end
      if (cfg_mid && k == 2 && !unmapped) begin
        cfg_we = 1'b1; cfg_dev = t_dev; cfg_ws = 4'($urandom_range(0, 4));
        model_ws[t_dev] = int'(cfg_ws);
      end
      data_in = (!unmapped && k == ws + 2) ? t_din : 16'($urandom);
      scramble();
      cpu_req = (k == last) ? keep_req : 1'($urandom);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, dummy;
    logic [2:0] rd;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_dev = 0; cpu_reg = 0; cpu_wdata = 0;
    data_in = 0; cfg_we = 0; cfg_dev = 0; cfg_ws = 0;
    for (int i = 0; i < 8; i++) model_ws[i] = 1;
    model_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    do_txn("wr_dev2", 1'b1, 3'd2, 2'd1, 16'hA5A5, 16'h0, 0, 0, 0, 4'd0, dummy);

    cfg_we = 1'b1; cfg_dev = 3'd5; cfg_ws = 4'd0; model_ws[5] = 0;
    @(negedge clk);
    cfg_we = 1'b0;
    do_txn("rd_dev5_ws0", 1'b0, 3'd5, 2'd2, 16'h0, 16'h1234, 0, 0, 0, 4'd0, dummy);
    do_txn("rd_dev7", 1'b0, 3'd7, 2'd0, 16'h0, 16'hBEEF, 0, 0, 0, 4'd0, dummy);

    cfg_we = 1'b1; cfg_dev = 3'd0; cfg_ws = 4'd2; model_ws[0] = 2;
    @(negedge clk);
    cfg_we = 1'b0;
    do_txn("b2b_0", 1'b0, 3'd0, 2'd0, 16'h0, 16'h1111, 1, 0, 0, 4'd0, a0);
    do_txn("b2b_1", 1'b0, 3'd0, 2'd1, 16'h0, 16'h2222, 1, 0, 0, 4'd0, a1);
    do_txn("b2b_2", 1'b0, 3'd0, 2'd2, 16'h0, 16'h3333, 0, 0, 0, 4'd0, a2);
    check("b2b_spacing_1", 16'(a1 - a0), 16'd6);
    check("b2b_spacing_2", 16'(a2 - a1), 16'd6);

    do_txn("cfg_at_accept", 1'b0, 3'd3, 2'd3, 16'h0, 16'h5A5A, 0, 1, 0, 4'd3, dummy);
    do_txn("cfg_mid", 1'b1, 3'd4, 2'd1, 16'hC3C3, 16'h0, 0, 0, 1, 4'd0, dummy);
    do_txn("after_mid", 1'b0, 3'd4, 2'd0, 16'h0, 16'h7E7E, 0, 0, 0, 4'd0, dummy);

    for (int i = 0; i < 40; i++) begin
      rd = 3'($urandom);
      do_txn("rand", 1'($urandom), rd, 2'($urandom), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 5)), dummy);
    end
    cpu_req = 1'b0;

    // Abort a long write with reset in the middle of ACCESS.
    cfg_we = 1'b1; cfg_dev = 3'd6; cfg_ws = 4'd15; model_ws[6] = 15;
    @(negedge clk);
    cfg_we = 1'b0;
    check_idle("pre_abort");
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_dev = 3'd6; cpu_reg = 2'd2; cpu_wdata = 16'h0F0F;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_we_before", we, 1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model_ws[i] = 1;
    model_rdata = 16'h0000;
    @(negedge clk);
    check_idle("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_ack", cpu_ack, 0);
    end
    do_txn("post_reset_dev6", 1'b0, 3'd6, 2'd1, 16'h0, 16'h4242, 0, 0, 0, 4'd0, dummy);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
